expr_check_sched: RTL
=====================

# expr_check_sched

Controller that schedules a byte stream of newline-terminated expressions through a single-character expression recognizer. It buffers incoming characters, feeds the recognizer one character per cycle, and detects the terminator. At the terminator it publishes an accept/reject verdict with the string length, then clears the recognizer for the next string. It sits between the character source (UART or testbench byte port) and the consumer of verdicts.

## Interface
- `FIFO_DEPTH`, 4: input buffer entries; power of 2, ≥2.
- `LEN_W`, 8: width of the length counter; saturates at 2^LEN_W−1.
- `TERM`, 8'h0A: terminator character; never fed to the recognizer.

- `clk` in 1: single clock, rising edge.
- `clr` in 1: synchronous, active-high reset.
- `in_valid` in 1: source offers `in_data`.
- `in_data` in 8: ASCII character.
- `in_ready` out 1: FIFO not full; a push occurs when `in_valid && in_ready`.
- `res_valid` out 1: verdict available.
- `res_ready` in 1: consumer takes the verdict.
- `res_accept` out 1: 1 means the string is well-formed.
- `res_len` out LEN_W: count of non-terminator characters, saturated.
- `res_overflow` out 1: length saturated; forces `res_accept=0`.
- `busy` out 1: FSM not IDLE or FIFO non-empty.

## Operation
- **Character classes.** Operator is 8'h2B '+' or 8'h2A '*'. Every other non-TERM byte is an operand.
- **Recognizer states:**
  - START: operand → OPND; operator → DEAD.
  - OPND: operator → OPER; operand → DEAD.
  - OPER: operand → OPND; operator → DEAD.
  - DEAD: absorbing.
  - Accept is asserted iff the state is OPND.
  - The recognizer steps only when the controller feeds it a character. A sync clear returns it to START.
- **Controller FSM:**
  - IDLE: the recognizer is in START and the length is 0. On a pop of TERM → REPORT (empty string: accept 0, len 0). On a pop of any other byte → SCAN, step the recognizer, len=1.
  - SCAN: each pop of a non-TERM byte steps the recognizer and increments len. A pop of TERM → REPORT. An empty FIFO means stall in SCAN.
  - REPORT: `res_valid=1`. No pops occur. `res_accept`, `res_len` and `res_overflow` are registered and stable until the handshake. On `res_valid && res_ready` → IDLE, and the recognizer and len are cleared.
- **Length counter.** When len is at 2^LEN_W−1, a further character leaves len unchanged and sets the sticky overflow for that string. `res_accept = rec_accept && !overflow`.
- **FIFO.** It is show-ahead. It pops when the FSM is in IDLE or SCAN and the count is greater than 0.
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - When full, `in_ready=0`. A pop that frees space raises `in_ready` on the next cycle; there is no same-cycle bypass.
- **Reset.** `clr` mid-operation empties the FIFO and discards any partial string or pending verdict. The FSM goes to IDLE and the recognizer to START.
- **Reset values:** `in_ready=1`, `res_valid=0`, `res_accept=0`, `res_len=0`, `res_overflow=0`, `busy=0`.

## Timing
- A byte pushed at edge t is popped no earlier than edge t+1.
- A recognizer step occurs at the pop edge.
- When TERM is popped at edge k, `res_valid` is high from cycle k+1.
- Minimum latency from TERM handshake to `res_valid` is 2 cycles.
- With `res_ready` held high, `res_valid` is high for exactly 1 cycle. IDLE resumes the cycle after the handshake, and the next pop can occur at that cycle's edge.
- Sustained throughput is one character per cycle, plus 2 cycles per string (REPORT and the handshake).
- `clr` takes priority over every other event in the same cycle.

## Structure
- **Shared package `expr_pkg`:**
  - Constants `CH_PLUS=8'h2B` and `CH_STAR=8'h2A`.
  - Recognizer state enum {START, OPND, OPER, DEAD}.
  - Controller state enum {IDLE, SCAN, REPORT}.
  - Function `is_operator(byte)`.
- **Sub-module `expr_recognizer`:** inputs `clk`, `clr`, `step`, `ch[7:0]`, `sclr`; output `accept`. The FIFO stays inline in the top.

## Test plan
- Stream "1+2*3\n" with `res_ready=1` → one verdict: accept=1, len=5, overflow=0, 2 cycles after the TERM handshake.
- Stream "12\n", then "+1\n", then "1+\n" → three verdicts in order, all accept=0, with len=2, 2, 2.
- Send "\n" alone → accept=0, len=0.
- Hold `res_ready=0` after "1\n", then push 6 bytes with FIFO_DEPTH=4 → 4 accepted, `in_ready=0` while the FSM is in REPORT. Release `res_ready` → verdict accept=1 len=1, then the buffered bytes drain in order.
- With LEN_W=2, send "1+2+3\n" → len=3, overflow=1, accept=0.
- Assert `clr` after "1+" → `res_valid` stays 0. Then "7\n" → accept=1, len=1.

Source files
------------

// File: rtl/expr_pkg.sv
// Shared types and helpers for the expression check scheduler.
// Character classes, recognizer states and controller states.
package expr_pkg;

    localparam logic [7:0] CH_PLUS = 8'h2B;
    localparam logic [7:0] CH_STAR = 8'h2A;

    typedef enum logic [1:0] {
        START,
        OPND,
        OPER,
        DEAD
    } rec_state_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        REPORT
    } ctl_state_t;

    function automatic logic is_operator(
        input logic [7:0] ch
    );
        return (ch == CH_PLUS) || (ch == CH_STAR);
    endfunction

endpackage

// File: rtl/expr_recognizer.sv
// Single-character recognizer for operand (operator operand)* strings.
// Steps only when fed; sclr returns it to START between strings.
module expr_recognizer
    import expr_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic       step,
    input  logic [7:0] ch,
    input  logic       sclr,
    output logic       accept
);

    rec_state_t r_state;
    rec_state_t w_state_nxt;
    logic       w_op;

    assign w_op = is_operator(ch);

    always_comb begin
        w_state_nxt = r_state;
        if (step) begin
            unique case (r_state)
                START:   w_state_nxt = w_op ? DEAD : OPND;
                OPND:    w_state_nxt = w_op ? OPER : DEAD;
                OPER:    w_state_nxt = w_op ? DEAD : OPND;
                DEAD:    w_state_nxt = DEAD;
                default: w_state_nxt = DEAD;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr || sclr) begin
            r_state <= START;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign accept = (r_state == OPND);

endmodule

// File: rtl/expr_check_sched.sv
// Buffers a byte stream, feeds the recognizer one byte per cycle and
// publishes an accept/reject verdict with length at each terminator.
module expr_check_sched
    import expr_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter int         LEN_W      = 8,
    parameter logic [7:0] TERM       = 8'h0A
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_accept,
    output logic [LEN_W-1:0] res_len,
    output logic             res_overflow,
    output logic             busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};

    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    ctl_state_t r_state;
    ctl_state_t w_state_nxt;

    logic [LEN_W-1:0] r_len;
    logic             r_ovf;

    logic       w_push;
    logic       w_pop;
    logic [7:0] w_head;
    logic       w_term;
    logic       w_step;
    logic       w_hs;
    logic       w_rec_acc;

    assign in_ready = (r_count != CNT_W'(FIFO_DEPTH));
    assign w_push   = in_valid && in_ready;
    assign w_pop    = (r_state != REPORT) && (r_count != '0);
    assign w_head   = r_mem[r_rptr];
    assign w_term   = (w_head == TERM);
    assign w_step   = w_pop && !w_term;
    assign w_hs     = (r_state == REPORT) && res_ready;

    // Storage is not reset; r_count alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_pop) begin
                    w_state_nxt = w_term ? REPORT : SCAN;
                end
            end
            SCAN: begin
                if (w_pop && w_term) begin
                    w_state_nxt = REPORT;
                end
            end
            REPORT: begin
                if (res_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Length saturates; the overflow flag sticks until the verdict is taken.
    always_ff @(posedge clk) begin
        if (clr || w_hs) begin
            r_len <= '0;
            r_ovf <= 1'b0;
        end else if (w_step) begin
            if (r_len == LEN_MAX) begin
                r_ovf <= 1'b1;
            end else begin
                r_len <= r_len + LEN_W'(1);
            end
        end
    end

    expr_recognizer u_rec (
        .clk    (clk),
        .clr    (clr),
        .step   (w_step),
        .ch     (w_head),
        .sclr   (w_hs),
        .accept (w_rec_acc)
    );

    assign res_valid    = (r_state == REPORT);
    assign res_accept   = res_valid && w_rec_acc && !r_ovf;
    assign res_len      = r_len;
    assign res_overflow = r_ovf;
    assign busy         = (r_state != IDLE) || (r_count != '0);

endmodule
